// File: rtl/conv_ifeed_pkg.sv
// Shared types and helpers for the conv_ifeed raster feeder.
// Pure declarations: no latency and no backpressure of its own.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WIN  = 2'd2,
        DONE = 2'd3
    } feed_state_t;

    // The bottom-right pixel of a full window sits at row, col >= kernel_dim-1;
    // smaller columns would make the window straddle a row edge.
    function automatic logic is_win_pos(input int unsigned row,
                                        input int unsigned col,
                                        input int unsigned kernel_dim);
        return (row >= kernel_dim - 1) && (col >= kernel_dim - 1);
    endfunction

endpackage

// File: rtl/conv_ifeed_if.sv
// Image-memory read port, line-buffer write port and window handshake of conv_ifeed.
// Wires only: latency and backpressure belong to the modules on each side.
interface conv_ifeed_if #(
    parameter int datatype_size = 8,
    parameter int addr_width    = 10,
    parameter int row_width     = 5,
    parameter int col_width     = 5
);
    logic                     o_rd_en;
    logic [addr_width-1:0]    o_rd_addr;
    logic [datatype_size-1:0] i_rd_data;
    logic                     o_write_enable;
    logic [datatype_size-1:0] o_data;
    logic                     o_window_valid;
    logic                     i_window_ready;
    logic [row_width-1:0]     o_out_row;
    logic [col_width-1:0]     o_out_col;

    modport master (
        output o_rd_en, o_rd_addr, o_write_enable, o_data,
               o_window_valid, o_out_row, o_out_col,
        input  i_rd_data, i_window_ready
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_write_enable, o_data,
               o_window_valid, o_out_row, o_out_col,
        output i_rd_data, i_window_ready
    );
endinterface

// File: rtl/conv_raster_cnt.sv
// Raster row/col/address counter with last-pixel and window-position flags.
// Advances one pixel per inc cycle; flags are combinational on the current pixel; no backpressure.
module conv_raster_cnt
    import conv_pkg::*;
#(
    parameter int img_width  = 28,
    parameter int img_height = 28,
    parameter int kernel_dim = 3,
    parameter int addr_width = $clog2(img_width * img_height),
    parameter int row_width  = $clog2(img_height),
    parameter int col_width  = $clog2(img_width)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [row_width-1:0]  row,
    output logic [col_width-1:0]  col,
    output logic [addr_width-1:0] addr,
    output logic                  last,
    output logic                  win
);
    localparam logic [row_width-1:0] ROW_MAX = row_width'(img_height - 1);
    localparam logic [col_width-1:0] COL_MAX = col_width'(img_width - 1);

    logic [row_width-1:0]  row_q, row_d;
    logic [col_width-1:0]  col_q, col_d;
    logic [addr_width-1:0] addr_q, addr_d;

    assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);
    assign win  = is_win_pos(32'(row_q), 32'(col_q), kernel_dim);
    assign row  = row_q;
    assign col  = col_q;
    assign addr = addr_q;

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (clr) begin
            row_d  = '0;
            col_d  = '0;
            addr_d = '0;
        end else if (inc) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            addr_d = last ? '0 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/conv_ifeed.sv
// Raster feeder: streams image memory into conv_ibuf and flags each complete window.
// Reads one pixel/cycle, window valid 2 cycles after its pixel read; pixel stream stalls until i_window_ready.
module conv_ifeed
    import conv_pkg::*;
#(
    parameter int datatype_size = 8,
    parameter int img_width     = 28,
    parameter int img_height    = 28,
    parameter int kernel_dim    = 3,
    parameter int addr_width    = $clog2(img_width * img_height)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    output logic         o_busy,
    output logic         o_done,
    conv_ifeed_if.master bus
);
    localparam int row_width = $clog2(img_height);
    localparam int col_width = $clog2(img_width);

    feed_state_t           state_q, state_d;
    logic                  win_vld_q, win_vld_d;
    logic                  wr_en_q, wr_en_d;
    logic                  last_q, last_d;
    logic [row_width-1:0]  out_row_q, out_row_d, cnt_row;
    logic [col_width-1:0]  out_col_q, out_col_d, cnt_col;
    logic [addr_width-1:0] cnt_addr;
    logic                  cnt_last, cnt_win, cnt_clr;
    logic                  handshake, rd_fire;

    conv_raster_cnt #(
        .img_width  (img_width),
        .img_height (img_height),
        .kernel_dim (kernel_dim),
        .addr_width (addr_width),
        .row_width  (row_width),
        .col_width  (col_width)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (rd_fire),
        .row   (cnt_row),
        .col   (cnt_col),
        .addr  (cnt_addr),
        .last  (cnt_last),
        .win   (cnt_win)
    );

    always_comb begin
        handshake = (state_q == WIN) && win_vld_q && bus.i_window_ready;
        // The read after an accepted window issues in the handshake cycle itself.
        rd_fire   = (state_q == READ) || (handshake && !last_q);
        state_d   = state_q;
        win_vld_d = win_vld_q;
        last_d    = last_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        wr_en_d   = rd_fire;
        cnt_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = READ;
                    cnt_clr = 1'b1;
                end
            end
            WIN: begin
                if (!win_vld_q) begin
                    win_vld_d = 1'b1;
                end else if (bus.i_window_ready) begin
                    win_vld_d = 1'b0;
                    state_d   = last_q ? DONE : READ;
                end
            end
            DONE: begin
                state_d = i_start ? READ : IDLE;
                cnt_clr = i_start;
            end
            default: ;
        endcase
        // A window-producing read parks the stream; the gap cycle lets its write land first.
        if (rd_fire && (cnt_win || cnt_last)) begin
            state_d   = WIN;
            last_d    = cnt_last;
            out_row_d = cnt_row - row_width'(kernel_dim - 1);
            out_col_d = cnt_col - col_width'(kernel_dim - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_vld_q <= 1'b0;
            wr_en_q   <= 1'b0;
            last_q    <= 1'b0;
            out_row_q <= '0;
            out_col_q <= '0;
        end else begin
            state_q   <= state_d;
            win_vld_q <= win_vld_d;
            wr_en_q   <= wr_en_d;
            last_q    <= last_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
        end
    end

    assign bus.o_rd_en        = rd_fire;
    assign bus.o_rd_addr      = cnt_addr;
    assign bus.o_write_enable = wr_en_q;
    assign bus.o_data         = wr_en_q ? bus.i_rd_data : '0;
    assign bus.o_window_valid = win_vld_q;
    assign bus.o_out_row      = out_row_q;
    assign bus.o_out_col      = out_col_q;
    assign o_busy             = (state_q == READ) || (state_q == WIN);
    assign o_done             = (state_q == DONE);

endmodule

// File: tb/tb_conv_ifeed.sv
// Randomized bench for conv_ifeed on a 4x4 image with a 3x3 kernel; memory returns index+1.
// A cycle-level timeline model predicts reads, writes, windows and done from the pixel rules.
module tb_conv_ifeed;
    localparam int W = 4, H = 4, K = 3, N = W * H, MAXC = 256;
    localparam int NWIN = (H - K + 1) * (W - K + 1);

    logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b0;
    logic o_busy, o_done;

    conv_ifeed_if #(.datatype_size(8), .addr_width(4), .row_width(2), .col_width(2)) bus ();

    conv_ifeed #(.datatype_size(8), .img_width(W), .img_height(H), .kernel_dim(K)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(i_start),
        .o_busy (o_busy),
        .o_done (o_done),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.o_rd_en) bus.i_rd_data <= 8'(bus.o_rd_addr) + 8'd1;

    int total = 0, bad = 0;
    bit pat[MAXC];
    bit e_rd[MAXC], e_we[MAXC], e_vld[MAXC];
    int e_addr[MAXC], e_data[MAXC], e_row[MAXC], e_col[MAXC];
    int e_done;

    // Timeline from the rules: reads back-to-back, window pixel -> write next cycle,
    // valid two cycles later until the first ready cycle, next read on that handshake.
    function automatic void build_model();
        int t, h;
        for (int i = 0; i < MAXC; i++) begin
            e_rd[i] = 0; e_we[i] = 0; e_vld[i] = 0;
            e_addr[i] = 0; e_data[i] = 0; e_row[i] = 0; e_col[i] = 0;
        end
        t = 1;
        for (int p = 0; p < N; p++) begin
            if (t >= MAXC - 4) break;
            e_rd[t] = 1; e_addr[t] = p;
            e_we[t + 1] = 1; e_data[t + 1] = p + 1;
            if (p / W >= K - 1 && p % W >= K - 1) begin
                h = t + 2;
                while (h < MAXC - 2 && !pat[h]) h++;
                for (int c = t + 2; c <= h; c++) begin
                    e_vld[c] = 1; e_row[c] = p / W - (K - 1); e_col[c] = p % W - (K - 1);
                end
                t = h;
            end else begin
                t = t + 1;
            end
        end
        e_done = t + 1;
    endfunction

    task automatic run_pass(input string nm, input int mid_start, input bit chained,
                            output int act_done);
        int nrd = 0, nwin = 0, age, want;
        bit prev_vld = 0, chk;
        int lb[$];
        act_done = -1;
        build_model();
        if (!chained) @(negedge clk);
        i_start = 1'b1;
        bus.i_window_ready = pat[0];
        for (int rc = 0; rc < MAXC; rc++) begin
            if (rc > 0) begin
                @(negedge clk);
                i_start = (rc == mid_start);
                bus.i_window_ready = pat[rc];
            end
            #1;
            chk = (rc > 0) || !chained;
            if (chk) begin
                total++;
                if (bus.o_rd_en !== e_rd[rc]) begin
                    bad++; $display("FAIL %s rd_en rc=%0d got=%b want=%b", nm, rc, bus.o_rd_en, e_rd[rc]);
                end
                if (e_rd[rc]) begin
                    total++;
                    if (bus.o_rd_addr !== 4'(e_addr[rc])) begin
                        bad++; $display("FAIL %s rd_addr rc=%0d got=%0d want=%0d", nm, rc, bus.o_rd_addr, e_addr[rc]);
                    end
                end
                total++;
                if (bus.o_write_enable !== e_we[rc]) begin
                    bad++; $display("FAIL %s write_enable rc=%0d got=%b want=%b", nm, rc, bus.o_write_enable, e_we[rc]);
                end
                if (e_we[rc]) begin
                    total++;
                    if (bus.o_data !== 8'(e_data[rc])) begin
                        bad++; $display("FAIL %s data rc=%0d got=%0d want=%0d", nm, rc, bus.o_data, e_data[rc]);
                    end
                end
                total++;
                if (bus.o_window_valid !== e_vld[rc]) begin
                    bad++; $display("FAIL %s window_valid rc=%0d got=%b want=%b", nm, rc, bus.o_window_valid, e_vld[rc]);
                end
                if (e_vld[rc]) begin
                    total++;
                    if (bus.o_out_row !== 2'(e_row[rc]) || bus.o_out_col !== 2'(e_col[rc])) begin
                        bad++; $display("FAIL %s coord rc=%0d got=(%0d,%0d) want=(%0d,%0d)", nm, rc,
                                        bus.o_out_row, bus.o_out_col, e_row[rc], e_col[rc]);
                    end
                end
                total++;
                if (o_done !== (rc == e_done) || o_busy !== (rc >= 1 && rc < e_done)) begin
                    bad++; $display("FAIL %s done/busy rc=%0d got=%b/%b want=%b/%b", nm, rc, o_done, o_busy,
                                    rc == e_done, rc >= 1 && rc < e_done);
                end
                if (o_done === 1'b1 && act_done < 0) act_done = rc;
                if (bus.o_rd_en === 1'b1) nrd++;
                if (bus.o_write_enable === 1'b1) lb.push_front(int'(bus.o_data));
                if (bus.o_window_valid === 1'b1 && !prev_vld) begin
                    nwin++;
                    for (int i = 0; i < K; i++) begin
                        for (int j = 0; j < K; j++) begin
                            age  = (K - 1 - i) * W + (K - 1 - j);
                            want = (e_row[rc] + i) * W + (e_col[rc] + j) + 1;
                            total++;
                            if (age >= lb.size() || lb[age] != want) begin
                                bad++; $display("FAIL %s tap(%0d,%0d) rc=%0d got=%0d want=%0d", nm, i, j, rc,
                                                (age < lb.size()) ? lb[age] : -1, want);
                            end
                        end
                    end
                end
                prev_vld = (bus.o_window_valid === 1'b1);
            end
            if (rc == e_done) break;
        end
        i_start = 1'b0;
        total++;
        if (nrd != N) begin bad++; $display("FAIL %s read_count got=%0d want=%0d", nm, nrd, N); end
        total++;
        if (nwin != NWIN) begin bad++; $display("FAIL %s window_count got=%0d want=%0d", nm, nwin, NWIN); end
    endtask

    task automatic check_all_zero(input string nm);
        total++;
        if (bus.o_rd_en !== 1'b0 || bus.o_rd_addr !== 4'd0 || bus.o_write_enable !== 1'b0 ||
            bus.o_data !== 8'd0 || bus.o_window_valid !== 1'b0 || bus.o_out_row !== 2'd0 ||
            bus.o_out_col !== 2'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL %s outputs got rd=%b a=%0d we=%b d=%0d v=%b r=%0d c=%0d busy=%b done=%b want all 0", nm,
                     bus.o_rd_en, bus.o_rd_addr, bus.o_write_enable, bus.o_data, bus.o_window_valid,
                     bus.o_out_row, bus.o_out_col, o_busy, o_done);
        end
    endtask

    function automatic void pat_all_ready();
        for (int i = 0; i < MAXC; i++) pat[i] = 1'b1;
    endfunction

    task automatic test_reset();
        bus.i_window_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        #1 check_all_zero("reset_idle");
    endtask

    task automatic test_ready_tied();
        int d;
        pat_all_ready();
        run_pass("ready_tied", -1, 0, d);
        total++;
        if (d != 22) begin bad++; $display("FAIL ready_tied done_cycle got=%0d want=22", d); end
    endtask

    task automatic test_stall();
        int d;
        pat_all_ready();
        for (int i = 13; i < 18; i++) pat[i] = 1'b0;
        run_pass("stall", -1, 0, d);
    endtask

    task automatic test_random_ready();
        int d;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < MAXC; i++) pat[i] = (i > 120) ? 1'b1 : ($urandom_range(0, 2) != 0);
            run_pass("random_ready", -1, 0, d);
        end
    endtask

    task automatic test_mid_start();
        int d;
        pat_all_ready();
        run_pass("mid_start", 6, 0, d);
    endtask

    task automatic test_reset_mid();
        int d;
        pat_all_ready();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1 check_all_zero("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        run_pass("after_reset", -1, 0, d);
    endtask

    task automatic test_back_to_back();
        int d;
        pat_all_ready();
        run_pass("b2b_first", -1, 0, d);
        run_pass("b2b_second", -1, 1, d);
        for (int i = 0; i < MAXC; i++) pat[i] = (i > 120) ? 1'b1 : ($urandom_range(0, 1) != 0);
        run_pass("b2b_third", -1, 1, d);
    endtask

    initial begin
        bus.i_window_ready = 1'b1;
        test_reset();
        test_ready_tied();
        test_stall();
        test_random_ready();
        test_mid_start();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_ifeed.md
# conv_ifeed

Raster-order feeder for the convolution input line buffer (`conv_ibuf`). It reads an `img_height` x `img_width` image from a one-cycle-latency image memory and drives the line buffer's write port. It flags each cycle in which the buffer holds a complete, in-bounds `kernel_dim` x `kernel_dim` window, and stalls the pixel stream until the downstream CIM compute stage accepts that window. It sits between image memory and `conv_ibuf`; the parent instantiates both side by side.

## Interface
- `datatype_size`, 8, pixel width in bits
- `img_width`, 28, image columns; must be >= `kernel_dim`
- `img_height`, 28, image rows; must be >= `kernel_dim`
- `kernel_dim`, 3, kernel side length
- `addr_width`, `$clog2(img_width*img_height)`, image memory address width

Ports:
- `clk`  in  1  clock; all logic on posedge
- `rst_n`  in  1  reset, asynchronous, active-low
- `i_start`  in  1  start one image pass; ignored while `o_busy`
- `o_busy`  out  1  pass in progress
- `o_done`  out  1  one-cycle pulse at end of pass
- `o_rd_en`  out  1  image memory read strobe
- `o_rd_addr`  out  `addr_width`  pixel index, equal to row*`img_width`+col
- `i_rd_data`  in  `datatype_size`  read data, valid the cycle after `o_rd_en`
- `o_write_enable`  out  1  line-buffer shift strobe
- `o_data`  out  `datatype_size`  line-buffer write data
- `o_window_valid`  out  1  line buffer holds a valid window
- `i_window_ready`  in  1  downstream accepts the window
- `o_out_row`, `o_out_col`  out  `$clog2(img_height)`, `$clog2(img_width)`  output coordinate of the current window

## Operation
- FSM states:
  - IDLE: on `i_start`, go to READ.
  - READ: issue reads. On a window-producing pixel, go to WIN. On the last pixel, go to WIN, since the last pixel is always window-producing.
  - WIN: hold `o_window_valid`.
    - Handshake on the final pixel goes to DONE.
    - Any other handshake goes back to READ, and the next read issues in the handshake cycle itself.
  - DONE: one cycle, then IDLE.
- Pixels are read in raster order, index 0 to H*W-1. Row and column counters wrap the column at `img_width`-1.
- `o_write_enable` is `o_rd_en` delayed one cycle; `o_data` = `i_rd_data` (combinational pass-through).
- Window-producing pixel: row >= `kernel_dim`-1 and col >= `kernel_dim`-1. This excludes the positions where the window would wrap across a row edge.
  - `o_out_row` = row-`kernel_dim`+1.
  - `o_out_col` = col-`kernel_dim`+1.
- While `o_window_valid` is high:
  - no read and no write occur;
  - the line-buffer contents are frozen;
  - `o_out_row`/`o_out_col` are stable.
- Handshake = `o_window_valid` and `i_window_ready` in the same cycle.
- Reset (any time, including mid-pass): state IDLE, counters 0. All outputs are 0, including any pending write, which is dropped.

## Timing
- `i_start` at cycle s: first `o_rd_en` at s+1; `o_busy` high from s+1.
- Non-window pixels: one read per cycle, back-to-back.
- Window pixel read at t:
  - no read at t+1;
  - write at t+1;
  - `o_window_valid` from t+2.
- With `i_window_ready` tied 1, consecutive window pixels are 2 cycles apart.
- Final handshake at h: at h+1, `o_done`=1 and `o_busy`=0; a new `i_start` is accepted at h+1.
- Reads per pass: exactly H*W. Windows per pass: exactly (H-K+1)*(W-K+1).

## Structure
- Package `conv_pkg`:
  - `feed_state_t` enum (IDLE, READ, WIN, DONE);
  - the window-position compare, as a function.
- Sub-module `conv_raster_cnt`: row/col counter with increment, last-pixel flag and window-position flag.

## Test plan
Common bench setup, W=H=4, K=3, memory returns index+1:
- Ready tied 1, `i_start` at cycle 0:
  - reads at cycles 1..11, 13, 15, 16, 17, 19;
  - windows at 13, 15, 19, 21 with coords (0,0), (0,1), (1,0), (1,1);
  - `o_done` at 22.
- Ready held low 5 cycles on the first window:
  - no `o_rd_en` and no `o_write_enable` during the stall;
  - `o_out_row`/`o_out_col` steady;
  - next read on the handshake cycle.
- `i_start` pulsed mid-pass: ignored; total reads still 16.
- `rst_n` low at cycle 8:
  - all outputs 0 immediately;
  - a fresh `i_start` replays from address 0.
- Back-to-back passes (`i_start` at the `o_done` cycle): second pass starts the next cycle with identical window data.
- Window data check: window (0,0) line-buffer taps equal pixels 1..11 in shift order.
